// File: rtl/dm_access_ctrl.sv
// Access controller between the MEM stage and a big-endian word-wide data memory.
// Optional per-response counters are enabled with `define DM_ACCESS_CNT_EN.
module dm_access_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_w_data,
  output logic              dm_w,
  output logic              dm_r,
  input  logic [31:0]       dm_r_data
`ifdef DM_ACCESS_CNT_EN
  ,
  output logic [15:0]       cnt_load,
  output logic [15:0]       cnt_store,
  output logic [15:0]       cnt_err
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         res_q, res_d;
  logic                err_q, err_d;
  logic [2:0]          bytes_s;
  logic [ADDR_W:0]     end_s;
  logic                chk_err_s;

  // Offset 0 is the most significant lane (big-endian).
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   load_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00: begin
        case (off)
          2'd0:    store_merge = {d[7:0], w[23:0]};
          2'd1:    store_merge = {w[31:24], d[7:0], w[15:0]};
          2'd2:    store_merge = {w[31:16], d[7:0], w[7:0]};
          default: store_merge = {w[31:8], d[7:0]};
        endcase
      end
      2'b01:   store_merge = off[1] ? {w[31:16], d[15:0]} : {d[15:0], w[15:0]};
      default: store_merge = d;
    endcase
  endfunction

  // Request check: illegal size, misalignment, or any byte beyond the memory.
  always_comb begin
    case (req_size)
      2'b00:   bytes_s = 3'd1;
      2'b01:   bytes_s = 3'd2;
      2'b10:   bytes_s = 3'd4;
      default: bytes_s = 3'd1;
    endcase
    end_s     = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, bytes_s};
    chk_err_s = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                (end_s > (ADDR_W+1)'(MEM_BYTES));
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          res_d   = 32'h0000_0000;
          err_d   = chk_err_s;
          merge_d = (req_we && !chk_err_s) ? req_wdata : 32'h0000_0000;
          if (chk_err_s) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size == 2'b10) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        res_d   = load_ext(dm_r_data, size_q, uns_q, addr_q[1:0]);
        state_d = RESP;
      end
      RMW_RD: begin
        merge_d = store_merge(dm_r_data, wdata_q, size_q, addr_q[1:0]);
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      merge_q <= 32'h0000_0000;
      res_q   <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Enables are Moore-decoded so the falling-edge write sees a stable dm_w.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = res_q;
  assign rsp_err   = err_q;
  assign dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_w_data = merge_q;
  assign dm_w      = (state_q == WRITE);
  assign dm_r      = (state_q == LOAD) || (state_q == RMW_RD);

`ifdef DM_ACCESS_CNT_EN
  logic [15:0] cnt_load_q, cnt_load_d;
  logic [15:0] cnt_store_q, cnt_store_d;
  logic [15:0] cnt_err_q, cnt_err_d;

  // Saturating counters, bumped once in each response cycle.
  always_comb begin
    cnt_load_d  = cnt_load_q;
    cnt_store_d = cnt_store_q;
    cnt_err_d   = cnt_err_q;
    if (state_q == RESP) begin
      if (err_q) begin
        cnt_err_d = (cnt_err_q == 16'hFFFF) ? cnt_err_q : cnt_err_q + 16'd1;
      end else if (we_q) begin
        cnt_store_d = (cnt_store_q == 16'hFFFF) ? cnt_store_q : cnt_store_q + 16'd1;
      end else begin
        cnt_load_d = (cnt_load_q == 16'hFFFF) ? cnt_load_q : cnt_load_q + 16'd1;
      end
    end else begin
      cnt_err_d = cnt_err_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load_q  <= 16'h0000;
      cnt_store_q <= 16'h0000;
      cnt_err_q   <= 16'h0000;
    end else begin
      cnt_load_q  <= cnt_load_d;
      cnt_store_q <= cnt_store_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_err   = cnt_err_q;
`endif

endmodule
